lane_serializer: RTL and testbench

- Sits directly downstream of the 96-bit lane shifter (8 lanes x 12 bits, lane shift with fill).
- Accepts one shifted 96-bit word plus the shifter's valid flag per handshake.
- Emits the word as a stream of 12-bit lanes, most-significant lane first, over a valid/ready interface.
- Drops words the shifter flagged invalid and counts them.

---
 rtl/lane_serializer.sv | 112 +++++++++++
 tb/tb_lane_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// Lane serializer: takes one shifted LANES x LANE_W word and emits it lane by lane, MS lane first.
// Optional macro LANE_SER_PIPE_EN allows a new word to load on the last-beat handshake (no bubble).
module lane_serializer #(
    parameter int LANE_W = 12,
    parameter int LANES  = 8,
    parameter int CNT_W  = 8,
    localparam int IW    = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*LANE_W-1:0] s_data,
    input  logic                    s_word_ok,
    input  logic [IW-1:0]           s_drop,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANE_W-1:0]       m_data,
    output logic [IW-1:0]           m_index,
    output logic                    m_last,
    output logic [CNT_W-1:0]        err_count,
    output logic                    busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                         state;
    logic                           live;
    logic [LANES-1:0][LANE_W-1:0]   hold;
    logic [IW-1:0]                  drop_q;
    logic [IW-1:0]                  nxt_idx;
    logic                           fire_in;
    logic                           fire_out;

    // live keeps s_ready low while reset is held and for the reset-release cycle boundary
`ifdef LANE_SER_PIPE_EN
    assign s_ready = live & ((state == IDLE) | (m_valid & m_ready & m_last));
`else
    assign s_ready = live & (state == IDLE);
`endif

    assign fire_in  = s_valid & s_ready;
    assign fire_out = m_valid & m_ready;
    assign nxt_idx  = m_index - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            live      <= 1'b0;
            hold      <= '0;
            drop_q    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            m_last    <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (fire_in) begin
                        if (s_word_ok) begin
                            hold    <= s_data;
                            drop_q  <= s_drop;
                            m_data  <= s_data[LANES*LANE_W-1 -: LANE_W];
                            m_index <= IW'(LANES-1);
                            m_last  <= (s_drop == IW'(LANES-1));
                            m_valid <= 1'b1;
                            busy    <= 1'b1;
                            state   <= SEND;
                        end else if (err_count != {CNT_W{1'b1}}) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (fire_out) begin
                        if (!m_last) begin
                            m_index <= nxt_idx;
                            m_data  <= hold[nxt_idx];
                            m_last  <= (nxt_idx == drop_q);
                        end else begin
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
`ifdef LANE_SER_PIPE_EN
                            // next word overlaps the final beat of the current one
                            if (fire_in) begin
                                if (s_word_ok) begin
                                    hold    <= s_data;
                                    drop_q  <= s_drop;
                                    m_data  <= s_data[LANES*LANE_W-1 -: LANE_W];
                                    m_index <= IW'(LANES-1);
                                    m_last  <= (s_drop == IW'(LANES-1));
                                    m_valid <= 1'b1;
                                    busy    <= 1'b1;
                                    state   <= SEND;
                                end else if (err_count != {CNT_W{1'b1}}) begin
                                    err_count <= err_count + 1'b1;
                                end
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_serializer.sv
// Directed + randomized bench for lane_serializer against a queue-based beat model.
module tb_lane_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [95:0] s_data;
    logic        s_word_ok;
    logic [2:0]  s_drop;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic [2:0]  m_index;
    logic        m_last;
    logic [7:0]  err_count;
    logic        busy;

    lane_serializer dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_word_ok(s_word_ok), .s_drop(s_drop),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic [2:0]  i;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    exp_err = 0;
    logic [95:0] w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected beats of a good word: lanes 7 down to drop
    task automatic model_word(input logic [95:0] d, input logic ok, input logic [2:0] drop);
        beat_t b;
        if (ok) begin
            for (int k = 7; k >= int'(drop); k--) begin
                b.d = d[12*k +: 12];
                b.i = 3'(k);
                b.l = (k == int'(drop));
                q.push_back(b);
            end
        end else if (exp_err < 255) begin
            exp_err++;
        end
    endtask

    task automatic push(input logic [95:0] d, input logic ok, input logic [2:0] drop);
        @(negedge clk);
        chk("s_ready_before_push", 32'(s_ready), 32'd1);
        s_valid = 1'b1; s_data = d; s_word_ok = ok; s_drop = drop;
        @(posedge clk);
        #1 s_valid = 1'b0;
        model_word(d, ok, drop);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles on lane 5
    task automatic drain(input int n, input int mode);
        int popped = 0;
        int cyc = 0;
        int stall = 0;
        bit stalled = 0;
        while (popped < n && cyc < 200) begin
            cyc++;
            @(negedge clk);
            chk("m_valid", 32'(m_valid), 32'd1);
            chk("m_data",  32'(m_data),  32'(q[0].d));
            chk("m_index", 32'(m_index), 32'(q[0].i));
            chk("m_last",  32'(m_last),  32'(q[0].l));
            chk("busy",    32'(busy),    32'd1);
            if (mode == 1) m_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && q[0].i == 3'd5 && !stalled) begin
                m_ready = (stall == 3);
                if (stall == 3) stalled = 1;
                stall++;
            end else m_ready = 1'b1;
            @(posedge clk);
            if (m_ready) begin
                void'(q.pop_front());
                popped++;
            end
        end
        chk("drain_beats", 32'(popped), 32'(n));
        #1 m_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_word_ok = 1'b0; s_drop = '0; m_ready = 1'b1;
        for (int k = 0; k < 8; k++) w[12*k +: 12] = 12'h800 + 12'(k);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data",  32'(m_data), 0);
        chk("rst_m_index", 32'(m_index), 0);
        chk("rst_m_last",  32'(m_last), 0);
        chk("rst_err",     32'(err_count), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);

        // full word, then drop=3, then drop=7
        push(w, 1'b1, 3'd0); drain(8, 0);
        @(negedge clk);
        chk("idle_m_valid", 32'(m_valid), 0);
        chk("idle_busy",    32'(busy), 0);
        push(w, 1'b1, 3'd3); drain(5, 0);
        push(w, 1'b1, 3'd7); drain(1, 0);

        // backpressure on lane 5
        push(w, 1'b1, 3'd0); drain(8, 2);

        // back-to-back good words
        push(w, 1'b1, 3'd0); drain(7, 0);
        @(negedge clk);
        chk("b2b_last", 32'(m_data), 32'h800);
        chk("b2b_last_flag", 32'(m_last), 1);
`ifdef LANE_SER_PIPE_EN
        chk("b2b_pipe_ready", 32'(s_ready), 1);
        s_valid = 1'b1; s_data = w; s_word_ok = 1'b1; s_drop = 3'd0;
        @(posedge clk);
        void'(q.pop_front());
        #1 s_valid = 1'b0;
        model_word(w, 1'b1, 3'd0);
`else
        chk("b2b_busy_ready", 32'(s_ready), 0);
        @(posedge clk);
        void'(q.pop_front());
        @(negedge clk);
        chk("b2b_bubble_valid", 32'(m_valid), 0);
        chk("b2b_bubble_ready", 32'(s_ready), 1);
        s_valid = 1'b1; s_data = w; s_word_ok = 1'b1; s_drop = 3'd0;
        @(posedge clk);
        #1 s_valid = 1'b0;
        model_word(w, 1'b1, 3'd0);
`endif
        drain(8, 0);

        // invalid words and saturation
        for (int n = 0; n < 3; n++) push(96'($urandom), 1'b0, 3'($urandom));
        @(negedge clk);
        chk("inv_m_valid", 32'(m_valid), 0);
        chk("err_3", 32'(err_count), 32'(exp_err));
        chk("err_3_abs", 32'(err_count), 3);
        for (int n = 0; n < 300; n++) push({$urandom, $urandom, $urandom}, 1'b0, 3'($urandom));
        @(negedge clk);
        chk("err_sat", 32'(err_count), 255);
        chk("sat_m_valid", 32'(m_valid), 0);
        push(w, 1'b1, 3'd2); drain(6, 1);
        @(negedge clk);
        chk("err_after_good", 32'(err_count), 255);

        // reset mid-word
        push(w, 1'b1, 3'd0); drain(3, 0);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_err",     32'(err_count), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        q.delete();
        exp_err = 0;
        @(negedge clk) rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_m_valid", 32'(m_valid), 0);
        end
        chk("post_rst_s_ready", 32'(s_ready), 1);

        // random words with random backpressure
        for (int n = 0; n < 40; n++) begin
            logic ok;
            logic [2:0] dr;
            ok = ($urandom_range(0, 3) != 0);
            dr = 3'($urandom);
            push({$urandom, $urandom, $urandom}, ok, dr);
            if (ok) drain(8 - int'(dr), 1);
            else begin
                @(negedge clk);
                chk("rnd_inv_valid", 32'(m_valid), 0);
            end
            chk("rnd_err", 32'(err_count), 32'(exp_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
